// File: rtl/led_pattern_ctrl_if.sv
// Board-side signal bundle for the LED pattern sequencer.
// The master drives the button and pause inputs. The slave (the sequencer) drives the LED outputs.
interface led_pattern_ctrl_if #(
   parameter int LED_COUNT = 4
);
   logic                 i_btn;
   logic                 i_pause;
   logic [LED_COUNT-1:0] o_led;
   logic [1:0]           o_mode;
   logic                 o_step;

   modport master (output i_btn, output i_pause,
                   input  o_led, input  o_mode, input o_step);
   modport slave  (input  i_btn, input  i_pause,
                   output o_led, output o_mode, output o_step);
endinterface

// File: rtl/led_pattern_ctrl.sv
// LED pattern sequencer. A free-running prescaler generates the step strobe.
// A debounced button cycles through the ROTL, ROTR, BOUNCE and BLINK patterns.
module led_pattern_ctrl #(
   parameter int COUNTER_WIDTH  = 25,
   parameter int LED_COUNT      = 4,
   parameter int DEBOUNCE_WIDTH = 16
) (
   input  logic                i_clk,
   input  logic                i_reset,
   led_pattern_ctrl_if.slave   bus
);

   typedef enum logic [1:0] {
      M_ROTL   = 2'd0,
      M_ROTR   = 2'd1,
      M_BOUNCE = 2'd2,
      M_BLINK  = 2'd3
   } mode_t;

   typedef enum logic {
      DIR_LEFT  = 1'b0,
      DIR_RIGHT = 1'b1
   } dir_t;

   localparam logic [LED_COUNT-1:0] SEED_LSB = LED_COUNT'(1);
   localparam logic [LED_COUNT-1:0] SEED_MSB = SEED_LSB << (LED_COUNT-1);

   mode_t                     r_mode, w_mode_next;
   dir_t                      r_dir, w_dir_next;
   logic [LED_COUNT-1:0]      r_led, w_led_next;
   logic                      r_step, w_step_next;
   logic [COUNTER_WIDTH-1:0]  r_cnt;
   logic                      r_stb;
   logic                      r_sync1, r_sync2, r_stable;
   logic [DEBOUNCE_WIDTH-1:0] r_db_cnt;
   logic                      w_db_fire, w_press;

   // The debounced level flips on the same edge that a press is acted upon.
   assign w_db_fire = (r_sync2 != r_stable) && (r_db_cnt == '1);
   assign w_press   = w_db_fire && r_sync2;

   // Button synchronizer and debounce counter
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_sync1  <= 1'b0;
         r_sync2  <= 1'b0;
         r_stable <= 1'b0;
         r_db_cnt <= '0;
      end else begin
         r_sync1 <= bus.i_btn;
         r_sync2 <= r_sync1;
         if (r_sync2 == r_stable) begin
            r_db_cnt <= '0;
         end else if (r_db_cnt == '1) begin
            r_stable <= r_sync2;
            r_db_cnt <= '0;
         end else begin
            r_db_cnt <= r_db_cnt + 1'b1;
         end
      end
   end

   // Prescaler; the strobe is the registered carry-out of the counter
   always_ff @(posedge i_clk) begin
      if (i_reset || w_press) begin
         r_cnt <= '0;
         r_stb <= 1'b0;
      end else if (bus.i_pause) begin
         r_stb <= 1'b0;
      end else begin
         {r_stb, r_cnt} <= {1'b0, r_cnt} + {{COUNTER_WIDTH{1'b0}}, 1'b1};
      end
   end

   // Mode state register
   always_ff @(posedge i_clk) begin
      if (i_reset) r_mode <= M_ROTL;
      else         r_mode <= w_mode_next;
   end

   // Mode next state: advance one pattern per debounced press
   always_comb begin
      w_mode_next = r_mode;
      if (w_press) begin
         unique case (r_mode)
            M_ROTL:   w_mode_next = M_ROTR;
            M_ROTR:   w_mode_next = M_BOUNCE;
            M_BOUNCE: w_mode_next = M_BLINK;
            M_BLINK:  w_mode_next = M_ROTL;
         endcase
      end
   end

   // Pattern datapath next values; a press reseeds and swallows a coincident step
   always_comb begin
      w_led_next  = r_led;
      w_dir_next  = r_dir;
      w_step_next = 1'b0;
      if (w_press) begin
         w_dir_next = DIR_LEFT;
         unique case (w_mode_next)
            M_ROTL:   w_led_next = SEED_LSB;
            M_ROTR:   w_led_next = SEED_MSB;
            M_BOUNCE: w_led_next = SEED_LSB;
            M_BLINK:  w_led_next = '1;
         endcase
      end else if (r_stb) begin
         w_step_next = 1'b1;
         unique case (r_mode)
            M_ROTL:   w_led_next = {r_led[LED_COUNT-2:0], r_led[LED_COUNT-1]};
            M_ROTR:   w_led_next = {r_led[0], r_led[LED_COUNT-1:1]};
            M_BOUNCE: begin
               if (r_dir == DIR_LEFT) begin
                  if (r_led[LED_COUNT-1]) begin
                     w_dir_next = DIR_RIGHT;
                     w_led_next = {1'b0, r_led[LED_COUNT-1:1]};
                  end else begin
                     w_led_next = {r_led[LED_COUNT-2:0], 1'b0};
                  end
               end else begin
                  if (r_led[0]) begin
                     w_dir_next = DIR_LEFT;
                     w_led_next = {r_led[LED_COUNT-2:0], 1'b0};
                  end else begin
                     w_led_next = {1'b0, r_led[LED_COUNT-1:1]};
                  end
               end
            end
            M_BLINK:  w_led_next = ~r_led;
         endcase
      end
   end

   // Pattern, direction and step-pulse registers
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_led  <= SEED_LSB;
         r_dir  <= DIR_LEFT;
         r_step <= 1'b0;
      end else begin
         r_led  <= w_led_next;
         r_dir  <= w_dir_next;
         r_step <= w_step_next;
      end
   end

   assign bus.o_led  = r_led;
   assign bus.o_mode = r_mode;
   assign bus.o_step = r_step;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Directed testbench for led_pattern_ctrl (COUNTER_WIDTH=2, DEBOUNCE_WIDTH=2, LED_COUNT=4).
module tb_led_pattern_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_vec  = 0;
   int   n_miss = 0;

   led_pattern_ctrl_if #(.LED_COUNT(4)) bus ();

   led_pattern_ctrl #(
      .COUNTER_WIDTH  (2),
      .LED_COUNT      (4),
      .DEBOUNCE_WIDTH (2)
   ) dut (
      .i_clk   (clk),
      .i_reset (rst),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Advance n rising edges, then settle 1 time unit past the edge.
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Hold the button for exactly the debounce latency; the press lands on the last edge.
   task automatic press_btn();
      bus.i_btn = 1'b1;
      tick(6);
      bus.i_btn = 1'b0;
   endtask

   task automatic release_btn();
      bus.i_btn = 1'b0;
      tick(6);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
   endtask

   initial begin
      bus.i_btn   = 1'b0;
      bus.i_pause = 1'b0;
      tick(2);
      chk("rst_led", bus.o_led, 4'b0001);
      chk("rst_mode", bus.o_mode, 2'd0);
      chk("rst_step", bus.o_step, 1'b0);
      rst = 1'b0;

      // 1: idle rotate-left
      tick(4);  chk("t1_e4_led", bus.o_led, 4'b0001); chk("t1_e4_step", bus.o_step, 1'b0);
      tick(1);  chk("t1_e5_led", bus.o_led, 4'b0010); chk("t1_e5_step", bus.o_step, 1'b1);
      tick(1);  chk("t1_e6_step", bus.o_step, 1'b0);
      tick(3);  chk("t1_e9_led", bus.o_led, 4'b0100); chk("t1_e9_step", bus.o_step, 1'b1);
      tick(4);  chk("t1_e13_led", bus.o_led, 4'b1000);
      tick(4);  chk("t1_e17_led", bus.o_led, 4'b0001);

      // 2: button held high
      bus.i_btn = 1'b1;
      tick(5);  chk("t2_pre_mode", bus.o_mode, 2'd0);
      tick(1);  chk("t2_mode", bus.o_mode, 2'd1); chk("t2_seed", bus.o_led, 4'b1000);
      chk("t2_step0", bus.o_step, 1'b0);
      tick(4);  chk("t2_wait_led", bus.o_led, 4'b1000);
      tick(1);  chk("t2_s1_led", bus.o_led, 4'b0100); chk("t2_s1_step", bus.o_step, 1'b1);
      tick(4);  chk("t2_s2_led", bus.o_led, 4'b0010);
      release_btn();

      // 3: bounce for eight steps
      press_btn();
      chk("t3_mode", bus.o_mode, 2'd2); chk("t3_seed", bus.o_led, 4'b0001);
      begin
         logic [3:0] exp_b [8] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100,
                                   4'b0010, 4'b0001, 4'b0010, 4'b0100};
         tick(5);
         chk("t3_b0", bus.o_led, exp_b[0]);
         for (int i = 1; i < 8; i++) begin
            tick(4);
            chk($sformatf("t3_b%0d", i), bus.o_led, exp_b[i]);
         end
      end
      release_btn();

      // 4: three-edge glitch must not register
      bus.i_btn = 1'b1;
      tick(3);
      bus.i_btn = 1'b0;
      tick(2);  chk("t4_db_peak", dut.r_db_cnt, 2'd3);
      tick(1);  chk("t4_db_clr", dut.r_db_cnt, 2'd0); chk("t4_mode", bus.o_mode, 2'd2);
      tick(4);  chk("t4_mode_late", bus.o_mode, 2'd2);

      // 5: pause mid-period
      do_reset();
      tick(6);  chk("t5_pre_led", bus.o_led, 4'b0010);
      bus.i_pause = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         chk($sformatf("t5_frz_led%0d", i), bus.o_led, 4'b0010);
         chk($sformatf("t5_frz_step%0d", i), bus.o_step, 1'b0);
      end
      bus.i_pause = 1'b0;
      tick(2);  chk("t5_rem_led", bus.o_led, 4'b0010); chk("t5_rem_step", bus.o_step, 1'b0);
      tick(1);  chk("t5_res_led", bus.o_led, 4'b0100); chk("t5_res_step", bus.o_step, 1'b1);
      // pause lands on the strobe edge: that step still happens, no further ones
      tick(3);
      bus.i_pause = 1'b1;
      tick(1);  chk("t5_ps_led", bus.o_led, 4'b1000); chk("t5_ps_step", bus.o_step, 1'b1);
      tick(4);  chk("t5_ps_hold", bus.o_led, 4'b1000); chk("t5_ps_nostep", bus.o_step, 1'b0);
      bus.i_pause = 1'b0;
      tick(4);  chk("t5_ps_wait", bus.o_led, 4'b1000);
      tick(1);  chk("t5_ps_next", bus.o_led, 4'b0001); chk("t5_ps_nstep", bus.o_step, 1'b1);

      // 6a: press coincides with a strobe; press wins
      do_reset();
      tick(3);
      bus.i_btn = 1'b1;
      tick(5);  chk("t6_pre_led", bus.o_led, 4'b0010); chk("t6_pre_mode", bus.o_mode, 2'd0);
      tick(1);  chk("t6_co_mode", bus.o_mode, 2'd1); chk("t6_co_led", bus.o_led, 4'b1000);
      chk("t6_co_step", bus.o_step, 1'b0);
      bus.i_btn = 1'b0;
      tick(5);  chk("t6_co_next", bus.o_led, 4'b0100); chk("t6_co_nstep", bus.o_step, 1'b1);
      tick(1);

      // 6b: into BLINK, then reset from BLINK
      press_btn();
      chk("t6_m2", bus.o_mode, 2'd2); chk("t6_m2_led", bus.o_led, 4'b0001);
      release_btn();
      press_btn();
      chk("t6_m3", bus.o_mode, 2'd3); chk("t6_m3_led", bus.o_led, 4'b1111);
      tick(5);  chk("t6_blk0", bus.o_led, 4'b0000);
      tick(4);  chk("t6_blk1", bus.o_led, 4'b1111);
      rst = 1'b1;
      tick(1);  chk("t6_rst_mode", bus.o_mode, 2'd0); chk("t6_rst_led", bus.o_led, 4'b0001);
      chk("t6_rst_step", bus.o_step, 1'b0);
      tick(1);
      rst = 1'b0;

      // 6c: press while paused, then four presses wrap back to ROTL
      bus.i_pause = 1'b1;
      press_btn();
      chk("t6_pp_mode", bus.o_mode, 2'd1); chk("t6_pp_led", bus.o_led, 4'b1000);
      release_btn();
      chk("t6_pp_hold", bus.o_led, 4'b1000);
      bus.i_pause = 1'b0;
      tick(4);  chk("t6_pp_wait", bus.o_led, 4'b1000); chk("t6_pp_wstep", bus.o_step, 1'b0);
      tick(1);  chk("t6_pp_step", bus.o_led, 4'b0100); chk("t6_pp_sflag", bus.o_step, 1'b1);
      release_btn();
      press_btn();  chk("t6_w2", bus.o_mode, 2'd2);
      release_btn();
      press_btn();  chk("t6_w3", bus.o_mode, 2'd3);
      release_btn();
      press_btn();  chk("t6_w0", bus.o_mode, 2'd0); chk("t6_w0_led", bus.o_led, 4'b0001);
      release_btn();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
